// File: rtl/ik_pkg.sv
// Shared key codes, command/mode types and reference pose tables for the arm jog controller.
// Pose entries are ordered base, shoulder, elbow, wrist (index 0..3).
package ik_pkg;

  localparam int MAX_JOINTS = 4;

  localparam logic [7:0] KEY_MODE = 8'h6D;
  localparam logic [7:0] KEY_HOME = 8'h72;
  localparam logic [7:0] KEY_W    = 8'h77;
  localparam logic [7:0] KEY_A    = 8'h61;
  localparam logic [7:0] KEY_S    = 8'h73;
  localparam logic [7:0] KEY_D    = 8'h64;
  localparam logic [7:0] KEY_D0   = 8'h30;
  localparam logic [7:0] KEY_D3   = 8'h33;
  localparam logic [7:0] KEY_UP   = 8'h6B;
  localparam logic [7:0] KEY_DN   = 8'h6A;

  typedef enum logic {PRESET = 1'b0, JOG = 1'b1} mode_t;
  typedef enum logic [1:0] {IDLE = 2'd0, DECODE = 2'd1, APPLY = 2'd2} cmd_state_t;

  // Packed so that element [i] is joint i: wrist is written first.
  typedef logic [MAX_JOINTS-1:0][23:0] pose_t;

  localparam pose_t HOME   = {24'd150000, 24'd145000, 24'd180000, 24'd150000};
  localparam pose_t POSE_W = {24'd150000, 24'd55000,  24'd180000, 24'd150000};
  localparam pose_t POSE_A = {24'd150000, 24'd100000, 24'd179000, 24'd150000};
  localparam pose_t POSE_S = {24'd150000, 24'd145000, 24'd181000, 24'd150000};
  localparam pose_t POSE_D = {24'd150000, 24'd185000, 24'd178000, 24'd150000};

  function automatic pose_t preset_pose(input logic [7:0] key);
    case (key)
      KEY_W:   return POSE_W;
      KEY_A:   return POSE_A;
      KEY_S:   return POSE_S;
      KEY_D:   return POSE_D;
      default: return HOME;
    endcase
  endfunction

endpackage

// File: rtl/ik_jog_controller_slew.sv
// Per-joint rate limiter: on each tick the angle moves at most SLEW_STEP toward the target.
// Reset loads reset_value; at_target is combinational from the current registers.
module slew_limiter #(
  parameter int ANGLE_W   = 24,
  parameter int SLEW_STEP = 500
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic [ANGLE_W-1:0] target,
  input  logic [ANGLE_W-1:0] reset_value,
  output logic [ANGLE_W-1:0] angle,
  output logic               at_target
);

  localparam logic [ANGLE_W-1:0] STEP = ANGLE_W'(SLEW_STEP);

  logic [ANGLE_W-1:0] angle_q, angle_d, diff;
  logic               rising;

  always_comb begin
    rising  = target > angle_q;
    diff    = rising ? (target - angle_q) : (angle_q - target);
    angle_d = angle_q;
    if (tick) begin
      // Large gaps step by STEP; the final partial step snaps exactly onto target.
      if (diff <= STEP)  angle_d = target;
      else if (rising)   angle_d = angle_q + STEP;
      else               angle_d = angle_q - STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) angle_q <= reset_value;
    else       angle_q <= angle_d;
  end

  assign angle     = angle_q;
  assign at_target = (angle_q == target);

endmodule

// File: rtl/ik_jog_controller.sv
// Keyboard-to-servo setpoint controller: PRESET poses or JOG single-joint steps, clamped and slewed.
// A byte accepted at edge N updates target_out/cmd_err after edge N+2; in_ready is low while decoding.
module ik_jog_controller
  import ik_pkg::*;
#(
  parameter int NUM_JOINTS = 3,
  parameter int ANGLE_W    = 24,
  parameter int ANGLE_MIN  = 50000,
  parameter int ANGLE_MAX  = 250000,
  parameter int JOG_STEP   = 5000,
  parameter int SLEW_STEP  = 500,
  parameter int TICK_DIV   = 100000,
  localparam int SEL_W     = (NUM_JOINTS > 1) ? $clog2(NUM_JOINTS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [NUM_JOINTS*ANGLE_W-1:0] target_out,
  output logic [NUM_JOINTS*ANGLE_W-1:0] angle_out,
  output logic [SEL_W-1:0]              sel_joint,
  output logic                          mode,
  output logic                          busy,
  output logic                          cmd_err
);

  typedef logic [NUM_JOINTS-1:0][ANGLE_W-1:0] tgt_t;

  localparam int             CNT_W  = $clog2(TICK_DIV);
  localparam logic [ANGLE_W:0] MIN_X  = (ANGLE_W+1)'(ANGLE_MIN);
  localparam logic [ANGLE_W:0] MAX_X  = (ANGLE_W+1)'(ANGLE_MAX);
  localparam logic [ANGLE_W:0] STEP_X = (ANGLE_W+1)'(JOG_STEP);

  function automatic logic [ANGLE_W-1:0] clamp_entry(input logic [23:0] p);
    logic [31:0] v;
    v = {8'd0, p};
    if (v < 32'(ANGLE_MIN))      v = 32'(ANGLE_MIN);
    else if (v > 32'(ANGLE_MAX)) v = 32'(ANGLE_MAX);
    return ANGLE_W'(v);
  endfunction

  function automatic tgt_t load_pose(input pose_t p);
    tgt_t t;
    for (int i = 0; i < NUM_JOINTS; i++) t[i] = clamp_entry(p[i]);
    return t;
  endfunction

  localparam tgt_t HOME_T = load_pose(HOME);

  cmd_state_t         state_q, state_d;
  logic [7:0]         byte_q, byte_d;
  mode_t              mode_q, mode_d, dec_mode_q, dec_mode_d;
  logic [SEL_W-1:0]   sel_q, sel_d, dec_sel_q, dec_sel_d;
  tgt_t               target_q, target_d, dec_target_q, dec_target_d;
  logic               dec_err_q, dec_err_d;
  logic               cmd_err_q, cmd_err_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic                  tick;
  tgt_t                  angle_w;
  logic [NUM_JOINTS-1:0] at_target;
  logic [ANGLE_W:0]      cur_ext, jog_up, jog_dn;
  logic [7:0]            dig;
  logic                  dig_ok;

  // Jog arithmetic carries one extra bit so neither direction can wrap.
  assign cur_ext = {1'b0, target_q[sel_q]};
  assign dig     = byte_q - KEY_D0;
  assign dig_ok  = (byte_q >= KEY_D0) && (byte_q <= KEY_D3) && (int'(dig) < NUM_JOINTS);

  always_comb begin
    jog_up = cur_ext + STEP_X;
    if (jog_up > MAX_X) jog_up = MAX_X;
    jog_dn = (cur_ext < MIN_X + STEP_X) ? MIN_X : (cur_ext - STEP_X);
  end

  always_comb begin
    state_d      = state_q;
    byte_d       = byte_q;
    mode_d       = mode_q;
    sel_d        = sel_q;
    target_d     = target_q;
    dec_mode_d   = dec_mode_q;
    dec_sel_d    = dec_sel_q;
    dec_target_d = dec_target_q;
    dec_err_d    = dec_err_q;
    cmd_err_d    = 1'b0;
    in_ready     = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          byte_d  = in_data;
          state_d = DECODE;
        end
      end
      DECODE: begin
        dec_mode_d   = mode_q;
        dec_sel_d    = sel_q;
        dec_target_d = target_q;
        dec_err_d    = 1'b0;
        case (byte_q)
          KEY_MODE: dec_mode_d = (mode_q == PRESET) ? JOG : PRESET;
          KEY_HOME: dec_target_d = HOME_T;
          KEY_W, KEY_A, KEY_S, KEY_D: begin
            if (mode_q == PRESET) dec_target_d = load_pose(preset_pose(byte_q));
            else                  dec_err_d    = 1'b1;
          end
          KEY_UP: begin
            if (mode_q == JOG) dec_target_d[sel_q] = jog_up[ANGLE_W-1:0];
            else               dec_err_d           = 1'b1;
          end
          KEY_DN: begin
            if (mode_q == JOG) dec_target_d[sel_q] = jog_dn[ANGLE_W-1:0];
            else               dec_err_d           = 1'b1;
          end
          default: begin
            if (mode_q == JOG && dig_ok) dec_sel_d = SEL_W'(dig);
            else                         dec_err_d = 1'b1;
          end
        endcase
        state_d = APPLY;
      end
      APPLY: begin
        if (dec_err_q) begin
          cmd_err_d = 1'b1;
        end else begin
          target_d = dec_target_q;
          mode_d   = dec_mode_q;
          sel_d    = dec_sel_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tick   = (cnt_q == CNT_W'(TICK_DIV - 1));
    cnt_d  = tick ? '0 : cnt_q + CNT_W'(1);
    busy_d = ~&at_target;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      byte_q       <= '0;
      mode_q       <= PRESET;
      sel_q        <= '0;
      target_q     <= HOME_T;
      dec_mode_q   <= PRESET;
      dec_sel_q    <= '0;
      dec_target_q <= HOME_T;
      dec_err_q    <= 1'b0;
      cmd_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      byte_q       <= byte_d;
      mode_q       <= mode_d;
      sel_q        <= sel_d;
      target_q     <= target_d;
      dec_mode_q   <= dec_mode_d;
      dec_sel_q    <= dec_sel_d;
      dec_target_q <= dec_target_d;
      dec_err_q    <= dec_err_d;
      cmd_err_q    <= cmd_err_d;
      busy_q       <= busy_d;
      cnt_q        <= cnt_d;
    end
  end

  for (genvar g = 0; g < NUM_JOINTS; g++) begin : g_joint
    slew_limiter #(
      .ANGLE_W  (ANGLE_W),
      .SLEW_STEP(SLEW_STEP)
    ) u_slew (
      .clk        (clk),
      .reset      (reset),
      .tick       (tick),
      .target     (target_q[g]),
      .reset_value(HOME_T[g]),
      .angle      (angle_w[g]),
      .at_target  (at_target[g])
    );
  end

  assign target_out = target_q;
  assign angle_out  = angle_w;
  assign sel_joint  = sel_q;
  assign mode       = mode_q;
  assign busy       = busy_q;
  assign cmd_err    = cmd_err_q;

endmodule

// File: tb/tb_ik_jog_controller.sv
// Bench for ik_jog_controller: key table with fixed expectations, a cycle-level reference model, and corner sequences.
module tb_ik_jog_controller;

  localparam int NJ = 3, AW = 24, AMIN = 50000, AMAX = 250000;
  localparam int JSTEP = 5000, SSTEP = 500, TDIV = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [7:0]      in_data = 8'h00;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [NJ*AW-1:0] target_out, angle_out;
  logic [1:0]      sel_joint;
  logic            mode, busy, cmd_err;

  ik_jog_controller #(
    .NUM_JOINTS(NJ), .ANGLE_W(AW), .ANGLE_MIN(AMIN), .ANGLE_MAX(AMAX),
    .JOG_STEP(JSTEP), .SLEW_STEP(SSTEP), .TICK_DIV(TDIV)
  ) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .target_out(target_out), .angle_out(angle_out), .sel_joint(sel_joint),
    .mode(mode), .busy(busy), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Pose tables as plain integers, ordered base, shoulder, elbow, wrist.
  int HOME_I[4] = '{150000, 180000, 145000, 150000};
  int PW_I[4]   = '{150000, 180000, 55000, 150000};
  int PA_I[4]   = '{150000, 179000, 100000, 150000};
  int PS_I[4]   = '{150000, 181000, 145000, 150000};
  int PD_I[4]   = '{150000, 178000, 185000, 150000};

  function automatic int clampi(input int v);
    return (v < AMIN) ? AMIN : (v > AMAX) ? AMAX : v;
  endfunction

  function automatic int pose_of(input logic [7:0] k, input int j);
    case (k)
      "w":     return PW_I[j];
      "a":     return PA_I[j];
      "s":     return PS_I[j];
      default: return PD_I[j];
    endcase
  endfunction

  // Reference model state, advanced once per rising edge.
  int m_tgt[NJ], m_ang[NJ];
  int m_mode, m_sel, m_cnt, m_pend;
  logic [7:0] m_byte;
  bit m_err, m_busy;

  task automatic m_apply(input logic [7:0] b);
    int d;
    case (b)
      "m": m_mode = 1 - m_mode;
      "r": for (int j = 0; j < NJ; j++) m_tgt[j] = clampi(HOME_I[j]);
      "w", "a", "s", "d": begin
        if (m_mode == 0) for (int j = 0; j < NJ; j++) m_tgt[j] = clampi(pose_of(b, j));
        else m_err = 1;
      end
      "k": if (m_mode == 1) m_tgt[m_sel] = clampi(m_tgt[m_sel] + JSTEP); else m_err = 1;
      "j": if (m_mode == 1) m_tgt[m_sel] = clampi(m_tgt[m_sel] - JSTEP); else m_err = 1;
      default: begin
        d = int'(b) - 48;
        if (m_mode == 1 && d >= 0 && d < NJ) m_sel = d; else m_err = 1;
      end
    endcase
  endtask

  always @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < NJ; j++) begin m_tgt[j] = HOME_I[j]; m_ang[j] = HOME_I[j]; end
      m_mode = 0; m_sel = 0; m_cnt = 0; m_pend = 0; m_err = 0; m_busy = 0;
    end else begin
      bit nb;
      nb = 0;
      for (int j = 0; j < NJ; j++) if (m_ang[j] != m_tgt[j]) nb = 1;
      if (m_cnt == TDIV - 1)
        for (int j = 0; j < NJ; j++) begin
          if (m_tgt[j] - m_ang[j] > SSTEP)       m_ang[j] += SSTEP;
          else if (m_tgt[j] - m_ang[j] < -SSTEP) m_ang[j] -= SSTEP;
          else                                    m_ang[j] = m_tgt[j];
        end
      m_cnt = (m_cnt + 1) % TDIV;
      m_err = 0;
      if (m_pend == 0) begin
        if (in_valid) begin m_byte = in_data; m_pend = 2; end
      end else begin
        m_pend--;
        if (m_pend == 0) m_apply(m_byte);
      end
      m_busy = nb;
    end
  end

  bit chk_on = 0;
  logic [NJ*AW-1:0] exp_t, exp_a;

  always @(negedge clk) if (chk_on) begin
    for (int j = 0; j < NJ; j++) begin
      exp_t[j*AW +: AW] = AW'(m_tgt[j]);
      exp_a[j*AW +: AW] = AW'(m_ang[j]);
    end
    check("cyc_target", target_out, exp_t);
    check("cyc_angle", angle_out, exp_a);
    check("cyc_mode", mode, m_mode);
    check("cyc_sel", sel_joint, m_sel);
    check("cyc_busy", busy, m_busy);
    check("cyc_cmd_err", cmd_err, m_err);
    check("cyc_in_ready", in_ready, m_pend == 0);
  end

  function automatic logic [AW-1:0] jt(input int j);
    return target_out[j*AW +: AW];
  endfunction
  function automatic logic [AW-1:0] ja(input int j);
    return angle_out[j*AW +: AW];
  endfunction

  // Offer one byte from a negedge; returns at the negedge after the result edge.
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    in_data = b; in_valid = 1'b1;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin
      check("send_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] key;
    int mode, sel;
    bit err;
    int jidx, jval;
  } vec_t;
  vec_t vt[$];

  function automatic void add(input logic [7:0] k, input int md, input int sl, input bit er,
                              input int ji, input int jv);
    vec_t v;
    v.key = k; v.mode = md; v.sel = sl; v.err = er; v.jidx = ji; v.jval = jv;
    vt.push_back(v);
  endfunction

  logic [NJ*AW-1:0] home_vec;
  int acc[4];
  logic [7:0] b2b[4];

  initial begin
    add("w", 0, 0, 0, 2, 55000);
    add("r", 0, 0, 0, 2, 145000);
    add("k", 0, 0, 1, 2, 145000);
    add("0", 0, 0, 1, 2, 145000);
    add("m", 1, 0, 0, 2, 145000);
    add("2", 1, 2, 0, 2, 145000);
    add("k", 1, 2, 0, 2, 150000);
    add("k", 1, 2, 0, 2, 155000);
    add("k", 1, 2, 0, 2, 160000);
    add("w", 1, 2, 1, 2, 160000);
    add("3", 1, 2, 1, 2, 160000);
    add("X", 1, 2, 1, 2, 160000);
    add("W", 1, 2, 1, 2, 160000);
    add("j", 1, 2, 0, 2, 155000);
    add("m", 0, 2, 0, 2, 155000);
    add("w", 0, 2, 0, 2, 55000);
    add("m", 1, 2, 0, 2, 55000);
    add("k", 1, 2, 0, 2, 60000);
    add("j", 1, 2, 0, 2, 55000);
    add("j", 1, 2, 0, 2, 50000);
    add("j", 1, 2, 0, 2, 50000);
    for (int i = 1; i <= 40; i++) add("k", 1, 2, 0, 2, 50000 + 5000 * i);
    add("k", 1, 2, 0, 2, 250000);
    add("1", 1, 1, 0, 1, 180000);
    add("k", 1, 1, 0, 1, 185000);
    add("0", 1, 0, 0, 0, 150000);
    add("j", 1, 0, 0, 0, 145000);
    add("d", 1, 0, 1, 2, 250000);
    add("m", 0, 0, 0, 0, 145000);
    add("a", 0, 0, 0, 1, 179000);
    add("r", 0, 0, 0, 2, 145000);

    for (int j = 0; j < NJ; j++) home_vec[j*AW +: AW] = AW'(HOME_I[j]);

    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_target", target_out, home_vec);
    check("rst_angle", angle_out, home_vec);
    check("rst_mode", mode, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    chk_on = 1;

    foreach (vt[i]) begin
      send(vt[i].key);
      check($sformatf("vec%0d_err", i), cmd_err, vt[i].err);
      check($sformatf("vec%0d_mode", i), mode, vt[i].mode);
      check($sformatf("vec%0d_sel", i), sel_joint, vt[i].sel);
      check($sformatf("vec%0d_tgt", i), jt(vt[i].jidx), vt[i].jval);
    end

    // Random keys drawn from the full key set plus junk; the model checks each cycle.
    for (int i = 0; i < 60; i++) begin
      logic [7:0] pool[14];
      pool = '{"m", "r", "w", "a", "s", "d", "0", "1", "2", "3", "k", "j", "Q", 8'h00};
      send(pool[$urandom_range(13)]);
      repeat ($urandom_range(3)) @(negedge clk);
    end

    // Full elbow descent from HOME to POSE_W.
    do_reset();
    send("w");
    check("slew_tgt", jt(2), 55000);
    begin
      int changes, bad, n;
      bit seen_busy;
      logic [AW-1:0] prev;
      changes = 0; bad = 0; seen_busy = 0; n = 0;
      prev = ja(2);
      while (n < 1000 && !(ja(2) == 55000 && busy == 1'b0)) begin
        @(negedge clk);
        n++;
        if (busy) seen_busy = 1;
        if (ja(2) != prev) begin
          changes++;
          if (prev - ja(2) != SSTEP) bad++;
          prev = ja(2);
        end
      end
      check("slew_timeout", n < 1000, 1);
      check("slew_ticks", changes, 180);
      check("slew_step", bad, 0);
      check("slew_final", ja(2), 55000);
      check("slew_busy_seen", seen_busy, 1);
      check("slew_busy_drop", busy, 0);
    end

    // Back-to-back bytes with in_valid held high.
    do_reset();
    b2b = '{"m", "1", "k", "k"};
    begin
      int idx;
      bit took;
      idx = 0;
      in_valid = 1'b1; in_data = b2b[0];
      for (int c = 0; c < 40 && idx < 4; c++) begin
        took = in_ready;
        if (took) acc[idx] = c;
        @(negedge clk);
        if (took) begin
          idx++;
          if (idx < 4) in_data = b2b[idx];
        end
      end
      in_valid = 1'b0;
      check("b2b_count", idx, 4);
      for (int i = 0; i < 3; i++) check($sformatf("b2b_gap%0d", i), acc[i+1] - acc[i], 3);
    end
    repeat (2) @(negedge clk);
    check("b2b_mode", mode, 1);
    check("b2b_sel", sel_joint, 1);
    check("b2b_shoulder", jt(1), 190000);

    // Reset while a byte sits in DECODE and the shoulder is mid-slew.
    check("mid_slew", ja(1) != jt(1), 1);
    in_data = "j"; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("dec_rst_target", target_out, home_vec);
    check("dec_rst_angle", angle_out, home_vec);
    check("dec_rst_mode", mode, 0);
    check("dec_rst_sel", sel_joint, 0);
    check("dec_rst_busy", busy, 0);
    check("dec_rst_ready", in_ready, 1);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("dec_rst_no_effect", target_out, home_vec);
    check("dec_rst_no_err", cmd_err, 0);

    chk_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
